rtc_tick_decoder: RTL
=====================

Name: rtc_tick_decoder

Overview:
- Receiving end of the divided-clock interface: takes the slow usr_clk square wave and quarter marker from the clock divider and turns them into single-cycle strobes in the clk domain.
- Keeps a BCD hh:mm:ss time-of-day counter advanced on each second strobe, with a valid/ready load port.
- Watchdog flags a stalled or missing usr_clk.
- Feeds the display/scoreboard logic.

Parameters:
- TIMEOUT_CYCLES, 26000000: clk cycles allowed between usr_clk edges of either polarity before tick_fault sets. Must exceed one half-period of 25000001.
- CNT_W, 25: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- usr_clk_in  in  1  divided clock level; toggles every 25000001 clk cycles
- quarter_in  in  1  quarter marker level; 4 rising edges per usr_clk period
- set_valid  in  1  load request
- set_hh  in  8  BCD hours, 00-23
- set_mm  in  8  BCD minutes, 00-59
- set_ss  in  8  BCD seconds, 00-59
- set_ready  out  1  load accepted when set_valid && set_ready
- set_err  out  1  one-cycle pulse: rejected (invalid BCD) load
- sec_tick  out  1  one-cycle strobe per usr_clk rising edge
- qtr_tick  out  1  one-cycle strobe per quarter_in rising edge
- qtr_phase  out  2  quarter ticks since last sec_tick, modulo 4
- hh  out  8  BCD hours
- mm  out  8  BCD minutes
- ss  out  8  BCD seconds
- tick_fault  out  1  sticky watchdog fault
- fault_clear  in  1  clears tick_fault

Behaviour:
- Reset value of every output is 0, including set_ready. During reset, prev_usr and prev_qtr load the current input levels, so no spurious edge is detected on release. set_ready goes to 1 in the first cycle after reset deasserts.
- Edge detect: inputs come from registered divider outputs in the same clock domain, so there is no synchroniser. sec_tick = usr_clk_in & ~prev_usr, registered. If the edge is sampled at edge N, sec_tick is high during cycle N+1. qtr_tick works the same way using quarter_in.
- qtr_phase:
  - sec_tick sets it to 0.
  - Otherwise qtr_tick increments it, wrapping from 3 to 0.
  - If both strobes occur in the same cycle, sec_tick wins and qtr_phase = 0.
- Time counter, on sec_tick:
  - ss increments in BCD. 59 goes to 00 with a carry into mm.
  - mm 59 goes to 00 with a carry into hh.
  - hh 23 goes to 00.
  - Each nibble is incremented separately: the low nibble goes 9 to 0 and carries into the high nibble.
- Load handshake:
  - Fire = set_valid & set_ready.
  - Validity: every nibble <= 9, ss <= 0x59, mm <= 0x59, hh <= 0x23.
  - Valid fire: hh/mm/ss take the set values on the next edge. Any sec_tick in the same cycle is dropped, so load has priority.
  - Invalid fire: time is unchanged and set_err pulses for 1 cycle.
  - After any fire, set_ready = 0 for exactly one cycle, then returns to 1. set_valid held high across that cycle does not fire twice.
- Watchdog:
  - wd_cnt clears on any usr_clk_in edge (rise or fall). Otherwise it increments and saturates at TIMEOUT_CYCLES.
  - When wd_cnt == TIMEOUT_CYCLES, tick_fault sets.
  - fault_clear clears tick_fault and wd_cnt. If the timeout condition and fault_clear coincide, fault_clear wins for that cycle.
  - tick_fault does not block time counting.
- Reset mid-operation aborts any pending load, clears time and fault, and returns to the post-reset state above.

Decomposition:
- Shared package rtc_pkg holds:
  - BCD limit constants: SEC_MAX 8'h59, MIN_MAX 8'h59, HR_MAX 8'h23.
  - The default half-period constant, 25000000, shared with the divider.
  - A 24-bit time-of-day struct/typedef {hh, mm, ss}.
- One natural sub-module, bcd_digit_pair: an 8-bit BCD counter with an inc input, a max input, a wrap-to-00 and a carry out. It is instantiated three times and chained through carries.

Test Plan:
- Reset release with usr_clk_in=1 and quarter_in=1 -> no sec_tick or qtr_tick; all outputs 0; set_ready=1 in the next cycle.
- usr_clk_in 0->1 sampled at edge N -> sec_tick high only in cycle N+1; ss 00->01; qtr_phase=0. Four quarter rises -> qtr_phase 1, 2, 3, 0.
- Load 23:59:58, then two sec_ticks -> 23:59:59, then 00:00:00. Load 00:09:59 plus one tick -> 00:10:00.
- set_valid with ss=0x5A (nibble > 9) or hh=0x24 -> set_err pulse, time unchanged, set_ready low for 1 cycle. A valid load in the same cycle as sec_tick -> loaded value exactly, with no increment.
- TIMEOUT_CYCLES=20 in sim, usr_clk_in held -> tick_fault sets after 20 cycles. fault_clear -> fault clears and resets after another 20 cycles. A usr_clk_in toggle every 10 cycles -> no fault.
- Reset asserted mid-count, at 12:34:56 with tick_fault=1 -> all outputs 0 on the next edge; no strobe on release.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared BCD limits, divider half-period and time-of-day type
package rtc_pkg;
    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX = 8'h23;
    localparam int unsigned HALF_PERIOD = 25000000;
    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } tod_t;
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] mx);
        return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= mx;
    endfunction
    function automatic logic tod_ok(input tod_t t);
        return bcd_ok(t.hh, HR_MAX) && bcd_ok(t.mm, MIN_MAX) && bcd_ok(t.ss, SEC_MAX);
    endfunction
endpackage

// File: rtl/rtc_tick_decoder_bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD counter wrapping to 00 after max, with carry out and load
module bcd_digit_pair (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] max,
    output logic [7:0] val,
    output logic       carry
);
    assign carry = inc && val == max;
    // load beats increment; low digit 9 rolls to 0 and bumps the high digit
    always_ff @(posedge clk)
        if (reset) val <= 8'h00;
        else if (load) val <= load_val;
        else if (inc) val <= carry ? 8'h00 : (val[3:0] == 4'd9 ? {val[7:4] + 4'd1, 4'd0} : {val[7:4], val[3:0] + 4'd1});
endmodule

// File: rtl/rtc_tick_decoder.sv
// rtc_tick_decoder: usr_clk/quarter edge strobes, BCD time of day, load port and watchdog
module rtc_tick_decoder
    import rtc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = HALF_PERIOD + 1000000,
    parameter int unsigned CNT_W = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usr_clk_in,
    input  logic       quarter_in,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_ready,
    output logic       set_err,
    output logic       sec_tick,
    output logic       qtr_tick,
    output logic [1:0] qtr_phase,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       tick_fault,
    input  logic       fault_clear
);
    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT_CYCLES);
    logic prev_usr, prev_qtr, fire, load_ok, tick, c_ss, c_mm, c_hh;
    logic [CNT_W-1:0] wd_cnt;
    tod_t set_t;
    assign set_t = '{hh: set_hh, mm: set_mm, ss: set_ss};
    assign fire = set_valid && set_ready;
    assign load_ok = fire && tod_ok(set_t);
    assign tick = sec_tick && !fire;
    // previous levels track inputs even in reset so release never shows a false edge
    always_ff @(posedge clk) begin
        prev_usr <= usr_clk_in;
        prev_qtr <= quarter_in;
    end
    // registered rising-edge strobes and quarter phase (second strobe wins)
    always_ff @(posedge clk)
        if (reset) begin
            sec_tick <= 1'b0;
            qtr_tick <= 1'b0;
            qtr_phase <= 2'd0;
        end else begin
            sec_tick <= usr_clk_in && !prev_usr;
            qtr_tick <= quarter_in && !prev_qtr;
            qtr_phase <= sec_tick ? 2'd0 : qtr_tick ? qtr_phase + 2'd1 : qtr_phase;
        end
    // load handshake: one dead cycle after every fire, error pulse on bad BCD
    always_ff @(posedge clk)
        if (reset) begin
            set_ready <= 1'b0;
            set_err <= 1'b0;
        end else begin
            set_ready <= !fire;
            set_err <= fire && !load_ok;
        end
    // watchdog counts clk cycles between usr_clk edges; fault is sticky until cleared
    always_ff @(posedge clk)
        if (reset || fault_clear) begin
            wd_cnt <= '0;
            tick_fault <= 1'b0;
        end else begin
            wd_cnt <= (usr_clk_in != prev_usr) ? '0 : (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;
            tick_fault <= tick_fault || wd_cnt == WD_MAX;
        end
    bcd_digit_pair u_ss (.clk(clk), .reset(reset), .inc(tick), .load(load_ok), .load_val(set_ss), .max(SEC_MAX), .val(ss), .carry(c_ss));
    bcd_digit_pair u_mm (.clk(clk), .reset(reset), .inc(c_ss), .load(load_ok), .load_val(set_mm), .max(MIN_MAX), .val(mm), .carry(c_mm));
    bcd_digit_pair u_hh (.clk(clk), .reset(reset), .inc(c_mm), .load(load_ok), .load_val(set_hh), .max(HR_MAX), .val(hh), .carry(c_hh));
    logic unused_ok;
    assign unused_ok = c_hh;
endmodule
